// File: rtl/line_buffer_3x3_if.sv
// Pixel-stream interface for the 3x3 line buffer.
// The producer side drives the raster pixels; the buffer side returns the column triplets.
interface line_buffer_3x3_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] pixel_i;
    logic                  valid_i;
    logic [DATA_WIDTH-1:0] S1_o;
    logic [DATA_WIDTH-1:0] S2_o;
    logic [DATA_WIDTH-1:0] S3_o;
    logic                  valid_o;
    logic                  frame_done_o;
    logic [9:0]            row_o;

    modport master (
        output pixel_i, valid_i,
        input  S1_o, S2_o, S3_o, valid_o, frame_done_o, row_o
    );

    modport slave (
        input  pixel_i, valid_i,
        output S1_o, S2_o, S3_o, valid_o, frame_done_o, row_o
    );
endinterface

// File: rtl/line_buffer_3x3.sv
// Turns a raster pixel stream into vertically aligned row taps (r-2, r-1, r)
// using two line memories; triplets are flagged valid once two lines are buffered.
module line_buffer_3x3 #(
    parameter int COLS       = 5,
    parameter int ROWS       = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    line_buffer_3x3_if.slave   bus
);
    localparam int AW = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [0:0] FILL   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [DATA_WIDTH-1:0] line_a [0:COLS-1];
    logic [DATA_WIDTH-1:0] line_b [0:COLS-1];

    logic [9:0]  col;
    logic [9:0]  row;
    logic [0:0]  state;
    logic [AW-1:0] col_idx;
    logic        last_col;
    logic        last_row;

    logic [DATA_WIDTH-1:0] s1_p1;
    logic [DATA_WIDTH-1:0] s2_p1;
    logic [DATA_WIDTH-1:0] s3_p1;
    logic [9:0]            row_p1;
    logic                  vld_p1;
    logic                  done_p1;

    assign col_idx  = col[AW-1:0];
    assign last_col = (col == 10'(COLS - 1));
    assign last_row = (row == 10'(ROWS - 1));

    // Line memories shift down one row per accepted pixel; reads above see pre-write values.
    always_ff @(posedge clk) begin
        if (bus.valid_i) begin
            line_b[col_idx] <= line_a[col_idx];
            line_a[col_idx] <= bus.pixel_i;
        end
    end

    // Stage p1: registered triplet, position counters and fill/stream control.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_p1   <= '0;
            s2_p1   <= '0;
            s3_p1   <= '0;
            row_p1  <= '0;
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
            col     <= '0;
            row     <= '0;
            state   <= FILL;
        end else begin
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
            if (bus.valid_i) begin
                s1_p1  <= line_b[col_idx];
                s2_p1  <= line_a[col_idx];
                s3_p1  <= bus.pixel_i;
                row_p1 <= row;

                if (last_col) begin
                    col <= '0;
                    row <= last_row ? 10'd0 : row + 10'd1;
                end else begin
                    col <= col + 10'd1;
                end

                case (state)
                    FILL: begin
                        if (row == 10'd1 && last_col) state <= STREAM;
                    end
                    default: begin
                        vld_p1 <= 1'b1;
                        if (last_row && last_col) begin
                            done_p1 <= 1'b1;
                            state   <= FILL;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.S1_o         = s1_p1;
    assign bus.S2_o         = s2_p1;
    assign bus.S3_o         = s3_p1;
    assign bus.row_o        = row_p1;
    assign bus.valid_o      = vld_p1;
    assign bus.frame_done_o = done_p1;
endmodule
